// File: rtl/renkon_layer_seq_pkg.sv
// Shared types for the renkon layer sequencer: field selects,
// FSM states and the per-layer descriptor record.
package renkon_seq_pkg;

  localparam int LWIDTH     = 16;
  localparam int MEMSIZE    = 12;
  localparam int NETSIZE    = 11;
  localparam int QLOG       = 4;
  localparam int NUM_FIELDS = 19;

  typedef enum logic [4:0] {
    FLD_IN_OFFSET  = 5'd0,
    FLD_OUT_OFFSET = 5'd1,
    FLD_NET_OFFSET = 5'd2,
    FLD_QBITS      = 5'd3,
    FLD_TOTAL_OUT  = 5'd4,
    FLD_TOTAL_IN   = 5'd5,
    FLD_IMG_HEIGHT = 5'd6,
    FLD_IMG_WIDTH  = 5'd7,
    FLD_FEA_HEIGHT = 5'd8,
    FLD_FEA_WIDTH  = 5'd9,
    FLD_CONV_KERN  = 5'd10,
    FLD_CONV_STRID = 5'd11,
    FLD_CONV_PAD   = 5'd12,
    FLD_BIAS_EN    = 5'd13,
    FLD_RELU_EN    = 5'd14,
    FLD_POOL_EN    = 5'd15,
    FLD_POOL_KERN  = 5'd16,
    FLD_POOL_STRID = 5'd17,
    FLD_POOL_PAD   = 5'd18
  } fld_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_e;

  typedef struct packed {
    logic [MEMSIZE-1:0] in_offset;
    logic [MEMSIZE-1:0] out_offset;
    logic [NETSIZE-1:0] net_offset;
    logic [QLOG-1:0]    qbits;
    logic [LWIDTH-1:0]  total_out;
    logic [LWIDTH-1:0]  total_in;
    logic [LWIDTH-1:0]  img_height;
    logic [LWIDTH-1:0]  img_width;
    logic [LWIDTH-1:0]  fea_height;
    logic [LWIDTH-1:0]  fea_width;
    logic [LWIDTH-1:0]  conv_kern;
    logic [LWIDTH-1:0]  conv_strid;
    logic [LWIDTH-1:0]  conv_pad;
    logic               bias_en;
    logic               relu_en;
    logic               pool_en;
    logic [LWIDTH-1:0]  pool_kern;
    logic [LWIDTH-1:0]  pool_strid;
    logic [LWIDTH-1:0]  pool_pad;
  } layer_desc_t;

endpackage

// File: rtl/renkon_layer_seq_if.sv
// Sequencer <-> renkon_ctrl link: req/ack handshake plus the
// layer configuration held for the duration of a job.
interface renkon_layer_seq_if;
  import renkon_seq_pkg::*;

  logic               req;
  logic               ack;
  logic [MEMSIZE-1:0] in_offset;
  logic [MEMSIZE-1:0] out_offset;
  logic [NETSIZE-1:0] net_offset;
  logic [QLOG-1:0]    qbits;
  logic [LWIDTH-1:0]  total_out;
  logic [LWIDTH-1:0]  total_in;
  logic [LWIDTH-1:0]  img_height;
  logic [LWIDTH-1:0]  img_width;
  logic [LWIDTH-1:0]  fea_height;
  logic [LWIDTH-1:0]  fea_width;
  logic [LWIDTH-1:0]  conv_kern;
  logic [LWIDTH-1:0]  conv_strid;
  logic [LWIDTH-1:0]  conv_pad;
  logic               bias_en;
  logic               relu_en;
  logic               pool_en;
  logic [LWIDTH-1:0]  pool_kern;
  logic [LWIDTH-1:0]  pool_strid;
  logic [LWIDTH-1:0]  pool_pad;

  modport master (
    output req, in_offset, out_offset, net_offset, qbits,
    output total_out, total_in, img_height, img_width,
    output fea_height, fea_width, conv_kern, conv_strid,
    output conv_pad, bias_en, relu_en, pool_en,
    output pool_kern, pool_strid, pool_pad,
    input  ack
  );

  modport slave (
    input  req, in_offset, out_offset, net_offset, qbits,
    input  total_out, total_in, img_height, img_width,
    input  fea_height, fea_width, conv_kern, conv_strid,
    input  conv_pad, bias_en, relu_en, pool_en,
    input  pool_kern, pool_strid, pool_pad,
    output ack
  );

endinterface

// File: rtl/renkon_layer_desc_ram.sv
// Descriptor table: per-field host writes, registered whole-record
// read. Storage is deliberately not reset.
module renkon_layer_desc_ram
  import renkon_seq_pkg::*;
#(
  parameter int MAX_LAYERS = 16,
  parameter int HWIDTH     = 32,
  localparam int AW        = $clog2(MAX_LAYERS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [4:0]        field,
  input  logic [HWIDTH-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output layer_desc_t       rdata
);

  layer_desc_t mem [MAX_LAYERS];
  logic        wr_ok;
  logic        unused_hi;

  assign unused_hi = ^wdata[HWIDTH-1:LWIDTH];
  assign wr_ok = we
              && (int'(field) < NUM_FIELDS)
              && (int'(waddr) < MAX_LAYERS);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      case (field)
        FLD_IN_OFFSET:
          mem[waddr].in_offset <= wdata[MEMSIZE-1:0];
        FLD_OUT_OFFSET:
          mem[waddr].out_offset <= wdata[MEMSIZE-1:0];
        FLD_NET_OFFSET:
          mem[waddr].net_offset <= wdata[NETSIZE-1:0];
        FLD_QBITS:
          mem[waddr].qbits <= wdata[QLOG-1:0];
        FLD_TOTAL_OUT:
          mem[waddr].total_out <= wdata[LWIDTH-1:0];
        FLD_TOTAL_IN:
          mem[waddr].total_in <= wdata[LWIDTH-1:0];
        FLD_IMG_HEIGHT:
          mem[waddr].img_height <= wdata[LWIDTH-1:0];
        FLD_IMG_WIDTH:
          mem[waddr].img_width <= wdata[LWIDTH-1:0];
        FLD_FEA_HEIGHT:
          mem[waddr].fea_height <= wdata[LWIDTH-1:0];
        FLD_FEA_WIDTH:
          mem[waddr].fea_width <= wdata[LWIDTH-1:0];
        FLD_CONV_KERN:
          mem[waddr].conv_kern <= wdata[LWIDTH-1:0];
        FLD_CONV_STRID:
          mem[waddr].conv_strid <= wdata[LWIDTH-1:0];
        FLD_CONV_PAD:
          mem[waddr].conv_pad <= wdata[LWIDTH-1:0];
        FLD_BIAS_EN:
          mem[waddr].bias_en <= wdata[0];
        FLD_RELU_EN:
          mem[waddr].relu_en <= wdata[0];
        FLD_POOL_EN:
          mem[waddr].pool_en <= wdata[0];
        FLD_POOL_KERN:
          mem[waddr].pool_kern <= wdata[LWIDTH-1:0];
        FLD_POOL_STRID:
          mem[waddr].pool_strid <= wdata[LWIDTH-1:0];
        FLD_POOL_PAD:
          mem[waddr].pool_pad <= wdata[LWIDTH-1:0];
        default: ;
      endcase
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/renkon_layer_seq.sv
// Host-side layer sequencer driving renkon_ctrl's req/ack handshake.
// Optional WAIT watchdog: define RENKON_LAYER_SEQ_TIMEOUT_EN.
module renkon_layer_seq
  import renkon_seq_pkg::*;
#(
  parameter int MAX_LAYERS = 16,
  parameter int HWIDTH     = 32,
  localparam int AW        = $clog2(MAX_LAYERS),
  localparam int NW        = $clog2(MAX_LAYERS + 1)
) (
  input  logic                clk,
  input  logic                xrst,
  input  logic                desc_we,
  input  logic [AW-1:0]       desc_layer,
  input  logic [4:0]          desc_field,
  input  logic [HWIDTH-1:0]   desc_wdata,
  input  logic [NW-1:0]       num_layers,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [AW-1:0]       layer_idx,
  output logic                err,
  renkon_layer_seq_if.master  ctl
);

  state_e      state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [NW-1:0] n_q;
  logic [NW-1:0] nl_c;
  layer_desc_t cfg_q;
  layer_desc_t rd_data;
  logic        last;
  logic        wd_hit;

  assign nl_c = (int'(num_layers) > MAX_LAYERS)
              ? NW'(MAX_LAYERS) : num_layers;
  assign last = (int'(idx_q) + 1 == int'(n_q));

  renkon_layer_desc_ram #(
    .MAX_LAYERS (MAX_LAYERS),
    .HWIDTH     (HWIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (desc_we && (state_q == IDLE)),
    .waddr (desc_layer),
    .field (desc_field),
    .wdata (desc_wdata),
    .raddr (idx_d),
    .rdata (rd_data)
  );

`ifdef RENKON_LAYER_SEQ_TIMEOUT_EN
  logic [23:0] wd_q;
  logic        err_q;

  assign wd_hit = (wd_q == '1);
  assign err    = err_q;

  // Counter idles at zero outside WAIT, so it restarts on each entry.
  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q <= (state_q == WAIT) ? wd_q + 24'd1 : '0;
      if (state_q == IDLE && start)
        err_q <= 1'b0;
      else if (state_q == WAIT && !ctl.ack && wd_hit)
        err_q <= 1'b1;
    end
  end
`else
  assign wd_hit = 1'b0;
  assign err    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          idx_d   = '0;
        end
      end
      // An empty run passes through FETCH without loading.
      FETCH: state_d = (n_q == '0) ? DONE : ISSUE;
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (ctl.ack) begin
          if (last) begin
            state_d = DONE;
          end else begin
            state_d = FETCH;
            idx_d   = idx_q + AW'(1);
          end
        end else if (wd_hit) begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      n_q     <= '0;
      cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_q == IDLE && start)
        n_q <= nl_c;
      if (state_q == FETCH && n_q != '0)
        cfg_q <= rd_data;
    end
  end

  assign busy = (state_q == FETCH)
             || (state_q == ISSUE)
             || (state_q == WAIT);
  assign done      = (state_q == DONE);
  assign layer_idx = idx_q;
  assign ctl.req   = (state_q == ISSUE);

  assign ctl.in_offset  = cfg_q.in_offset;
  assign ctl.out_offset = cfg_q.out_offset;
  assign ctl.net_offset = cfg_q.net_offset;
  assign ctl.qbits      = cfg_q.qbits;
  assign ctl.total_out  = cfg_q.total_out;
  assign ctl.total_in   = cfg_q.total_in;
  assign ctl.img_height = cfg_q.img_height;
  assign ctl.img_width  = cfg_q.img_width;
  assign ctl.fea_height = cfg_q.fea_height;
  assign ctl.fea_width  = cfg_q.fea_width;
  assign ctl.conv_kern  = cfg_q.conv_kern;
  assign ctl.conv_strid = cfg_q.conv_strid;
  assign ctl.conv_pad   = cfg_q.conv_pad;
  assign ctl.bias_en    = cfg_q.bias_en;
  assign ctl.relu_en    = cfg_q.relu_en;
  assign ctl.pool_en    = cfg_q.pool_en;
  assign ctl.pool_kern  = cfg_q.pool_kern;
  assign ctl.pool_strid = cfg_q.pool_strid;
  assign ctl.pool_pad   = cfg_q.pool_pad;

endmodule

// File: tb/tb_renkon_layer_seq.sv
// Self-checking bench for renkon_layer_seq: descriptor table model,
// timing of req/done per run, corner sequences and random runs.
module tb_renkon_layer_seq;

  logic        clk = 1'b0;
  logic        xrst;
  logic        desc_we;
  logic [3:0]  desc_layer;
  logic [4:0]  desc_field;
  logic [31:0] desc_wdata;
  logic [4:0]  num_layers;
  logic        start;
  logic        busy;
  logic        done;
  logic [3:0]  layer_idx;
  logic        err;

  renkon_layer_seq_if ifc ();

  renkon_layer_seq dut (
    .clk        (clk),
    .xrst       (xrst),
    .desc_we    (desc_we),
    .desc_layer (desc_layer),
    .desc_field (desc_field),
    .desc_wdata (desc_wdata),
    .num_layers (num_layers),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .layer_idx  (layer_idx),
    .err        (err),
    .ctl        (ifc.master)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] mdl [16][19];

  typedef struct {
    int          fld;
    logic [31:0] wd;
    int          chk_fld;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] fmask(input int f);
    case (f)
      0, 1:       return 32'hFFF;
      2:          return 32'h7FF;
      3:          return 32'hF;
      13, 14, 15: return 32'h1;
      default:    return 32'hFFFF;
    endcase
  endfunction

  function automatic logic [31:0] dut_field(input int f);
    case (f)
      0:  return 32'(ifc.in_offset);
      1:  return 32'(ifc.out_offset);
      2:  return 32'(ifc.net_offset);
      3:  return 32'(ifc.qbits);
      4:  return 32'(ifc.total_out);
      5:  return 32'(ifc.total_in);
      6:  return 32'(ifc.img_height);
      7:  return 32'(ifc.img_width);
      8:  return 32'(ifc.fea_height);
      9:  return 32'(ifc.fea_width);
      10: return 32'(ifc.conv_kern);
      11: return 32'(ifc.conv_strid);
      12: return 32'(ifc.conv_pad);
      13: return 32'(ifc.bias_en);
      14: return 32'(ifc.relu_en);
      15: return 32'(ifc.pool_en);
      16: return 32'(ifc.pool_kern);
      17: return 32'(ifc.pool_strid);
      default: return 32'(ifc.pool_pad);
    endcase
  endfunction

  function automatic logic [31:0] cfg_or();
    logic [31:0] acc = '0;
    for (int f = 0; f < 19; f++) acc |= dut_field(f);
    return acc;
  endfunction

  task automatic wr(input int lay, input int f, input logic [31:0] v);
    desc_we    = 1'b1;
    desc_layer = 4'(lay);
    desc_field = 5'(f);
    desc_wdata = v;
    tick();
    desc_we = 1'b0;
    if (f < 19) mdl[lay][f] = v & fmask(f);
  endtask

  task automatic check_cfg(input int l, input string tag);
    for (int f = 0; f < 19; f++)
      chk($sformatf("%s cfg L%0d F%0d", tag, l, f),
          dut_field(f), mdl[l][f]);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " req"}, 32'(ifc.req), 0);
    chk({tag, " err"}, 32'(err), 0);
    chk({tag, " idx"}, 32'(layer_idx), 0);
    chk({tag, " cfg"}, cfg_or(), 0);
  endtask

  // Expected: req 2 cycles after start and after each non-final ack,
  // done 1 cycle after the final ack; config held until next FETCH edge.
  task automatic run(input int n, input int dmin, input int dmax);
    int ne;
    int d;
    ne = (n > 16) ? 16 : n;
    num_layers = 5'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start busy", 32'(busy), 1);
    chk("start req", 32'(ifc.req), 0);
    if (ne == 0) begin
      tick();
      chk("n0 done", 32'(done), 1);
      chk("n0 busy", 32'(busy), 0);
      chk("n0 req", 32'(ifc.req), 0);
      tick();
      chk("n0 idle", {30'd0, done, busy}, 0);
      return;
    end
    tick();
    for (int l = 0; l < ne; l++) begin
      chk($sformatf("req L%0d", l), 32'(ifc.req), 1);
      chk($sformatf("idx L%0d", l), 32'(layer_idx), 32'(l));
      check_cfg(l, "issue");
      d = $urandom_range(dmax, dmin);
      for (int k = 0; k < d; k++) begin
        tick();
        chk($sformatf("wait L%0d", l),
            {29'd0, ifc.req, done, busy}, 32'b001);
      end
      ifc.ack = 1'b1;
      tick();
      ifc.ack = 1'b0;
      if (l == ne - 1) begin
        chk("done", 32'(done), 1);
        chk("done busy", 32'(busy), 0);
        chk("done err", 32'(err), 0);
        tick();
        chk("post done", {30'd0, done, busy}, 0);
      end else begin
        chk("fetch busy", 32'(busy), 1);
        chk("fetch req", 32'(ifc.req), 0);
        chk("fetch idx", 32'(layer_idx), 32'(l + 1));
        check_cfg(l, "hold");
        tick();
      end
    end
  endtask

  initial begin
    xrst       = 1'b1;
    desc_we    = 1'b0;
    desc_layer = '0;
    desc_field = '0;
    desc_wdata = '0;
    num_layers = '0;
    start      = 1'b0;
    ifc.ack    = 1'b0;

    tick();
    tick();
    check_zero("reset");
    xrst = 1'b0;
    tick();
    check_zero("post reset");

    for (int l = 0; l < 16; l++)
      for (int f = 0; f < 19; f++) wr(l, f, 32'd0);

    // Two-layer scenario with ack 10 cycles after each req.
    wr(0, 6, 12);
    wr(0, 10, 5);
    wr(0, 14, 1);
    wr(1, 6, 4);
    wr(1, 15, 1);
    run(2, 10, 10);
    chk("img_height L1 final", 32'(ifc.img_height), 4);

    // Stray ack in IDLE.
    ifc.ack = 1'b1;
    tick();
    ifc.ack = 1'b0;
    tick();
    chk("stray ack idle", {29'd0, ifc.req, done, busy}, 0);
    chk("stray ack idx", 32'(layer_idx), 1);

    run(0, 1, 1);

    // Start/desc_we while busy, ack coincident with req.
    num_layers = 5'd2;
    start = 1'b1;
    tick();
    chk("cb fetch busy", 32'(busy), 1);
    num_layers = 5'd1;
    desc_we    = 1'b1;
    desc_layer = 4'd0;
    desc_field = 5'd6;
    desc_wdata = 32'd99;
    tick();
    chk("cb req", 32'(ifc.req), 1);
    start   = 1'b0;
    desc_we = 1'b0;
    ifc.ack = 1'b1;
    tick();
    ifc.ack = 1'b0;
    chk("cb ack@req ignored", {28'd0, layer_idx}, 0);
    repeat (3) tick();
    chk("cb still wait", {29'd0, ifc.req, done, busy}, 32'b001);
    chk("cb idx", 32'(layer_idx), 0);
    ifc.ack = 1'b1;
    tick();
    ifc.ack = 1'b0;
    chk("cb idx1", 32'(layer_idx), 1);
    tick();
    chk("cb req L1", 32'(ifc.req), 1);
    check_cfg(1, "cb");
    tick();
    ifc.ack = 1'b1;
    tick();
    ifc.ack = 1'b0;
    chk("cb done", 32'(done), 1);
    tick();
    run(1, 2, 2);
    chk("table frozen", 32'(ifc.img_height), 12);

    // Reset during WAIT of layer 1 of 3.
    wr(2, 7, 32'h1234);
    num_layers = 5'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    ifc.ack = 1'b1;
    tick();
    ifc.ack = 1'b0;
    tick();
    tick();
    chk("mr in wait", {28'd0, layer_idx}, 1);
    xrst = 1'b1;
    #1;
    check_zero("mid reset");
    tick();
    xrst = 1'b0;
    tick();
    check_zero("after mid reset");
    run(3, 1, 4);

    // Field truncation and out-of-range field selects.
    vecs[0] = '{3,  32'hFFFF_FFFF, 3,  32'hF};
    vecs[1] = '{25, 32'h0,         3,  32'hF};
    vecs[2] = '{0,  32'hFFFF_FFFF, 0,  32'hFFF};
    vecs[3] = '{2,  32'h000A_BCDE, 2,  32'h4DE};
    vecs[4] = '{13, 32'h2,         13, 32'h0};
    vecs[5] = '{14, 32'h3,         14, 32'h1};
    vecs[6] = '{6,  32'h0001_2345, 6,  32'h2345};
    vecs[7] = '{19, 32'h5,         6,  32'h2345};
    for (int i = 0; i < 8; i++) begin
      wr(0, vecs[i].fld, vecs[i].wd);
      run(1, 1, 2);
      chk($sformatf("vec%0d f%0d", i, vecs[i].chk_fld),
          dut_field(vecs[i].chk_fld), vecs[i].exp);
    end

    run(20, 1, 2);
    chk("clamp idx", 32'(layer_idx), 15);

    for (int it = 0; it < 8; it++) begin
      int nw;
      nw = $urandom_range(6, 1);
      for (int w = 0; w < nw; w++)
        wr($urandom_range(15, 0), $urandom_range(21, 0), $urandom);
      tick();
      run($urandom_range(5, 1), 1, 5);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
